heard_serializer: RTL and testbench
===================================

HEARD_SERIALIZER -- requirements
Module: heard_serializer

Interface
REQ-001 Parameter: TAG, 16'h0001, value placed in the upper half of every header word.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update only on the rising edge of CLK.
REQ-003 Port: CLK  input  1  clock.
REQ-004 Port: RST  input  1  synchronous active-high reset.
REQ-005 Port: heard__ENA  input  1  upstream indication enable; the message is taken only when heard__RDY is also high.
REQ-006 Port: heard_meth  input  192  method payload, sampled on acceptance.
REQ-007 Port: heard_v  input  192  value payload, sampled on acceptance.
REQ-008 Port: heard__RDY  output  1  block can accept a message this cycle.
REQ-009 Port: out__ENA  output  1  out_data valid toward host link.
REQ-010 Port: out_data  output  32  serialized word.
REQ-011 Port: out_last  output  1  current word is the final word of a packet.
REQ-012 Port: out__RDY  input  1  host link accepts the word this cycle.
REQ-013 Port: pkt_count  output  16  number of packets fully emitted, modulo 2^16.

Function
REQ-014 Acceptance: heard__ENA && heard__RDY SHALL capture heard_meth and heard_v into a 384-bit holding register and move the FSM from IDLE to HDR on the next edge.
REQ-015 heard__RDY SHALL be 1 exactly when the FSM is in IDLE; it SHALL be a registered-state decode with no combinational path from heard__ENA or out__RDY.
REQ-016 FSM states: IDLE, HDR, PAY; no other states are reachable.
REQ-017 Word transfer: a word is transferred on any edge where out__ENA && out__RDY.
REQ-018 out__ENA SHALL be 1 in HDR and PAY and 0 in IDLE.
REQ-019 While out__ENA=1 and out__RDY=0, out_data and out_last SHALL hold stable; there is no timeout.
REQ-020 HDR: out_data = {TAG, 16'd12}; a transfer SHALL move the FSM to PAY with the word index at 0.
REQ-021 PAY: the 4-bit word index k runs 0..11.
REQ-022 For k=0..5, out_data = heard_meth[32k+31:32k], least-significant word first.
REQ-023 For k=6..11, out_data = heard_v[32(k-6)+31:32(k-6)].
REQ-024 Each transfer in PAY SHALL increment k; k SHALL never exceed 11.
REQ-025 out_last SHALL be 1 only in PAY with k=11.
REQ-026 A transfer at k=11 SHALL return the FSM to IDLE, clear k and increment pkt_count, wrapping from 16'hFFFF to 16'h0000.
REQ-027 A packet is 13 words. Minimum latency from acceptance to the header on out_data is 1 cycle. Best-case packet occupancy is 13 cycles after the acceptance edge, so the maximum throughput is one message per 14 cycles.
REQ-028 heard_meth and heard_v SHALL be ignored while heard__RDY=0; the holding register SHALL change only on acceptance.
REQ-029 Holding-register contents in IDLE are don't-care; out_data SHALL be 32'h0 in IDLE.

Reset
REQ-030 RST=1 at a clock edge SHALL force FSM=IDLE, k=0, pkt_count=0 and the holding register to 0.
REQ-031 The output values following reset SHALL be heard__RDY=1, out__ENA=0, out_last=0 and out_data=0.
REQ-032 Reset asserted mid-packet SHALL discard the in-flight packet without emitting further words; pkt_count SHALL NOT count the discarded packet.
REQ-033 A heard__ENA in the same cycle as RST=1 SHALL be dropped.

Verification
REQ-034 Single message: meth = 192'h...0605040302010 pattern (word i = i+1), v word i = 32'hA0+i, out__RDY tied to 1 -> words 32'h0001000C, 1,2,3,4,5,6, A0..A5 on consecutive cycles; out_last only on A5; pkt_count becomes 1.
REQ-035 Backpressure: same stimulus with out__RDY toggling 1,0,0,1,... -> identical word sequence, data stable during stalls, no duplicates or drops.
REQ-036 Back-to-back: heard__ENA held at 1 with two distinct messages -> second accepted exactly in the cycle after the first packet's last transfer; heard__RDY=0 for the 13 intervening cycles.
REQ-037 Mid-packet reset: RST pulsed after 5 transferred words -> next cycle out__ENA=0, heard__RDY=1, pkt_count unchanged (0); a subsequent message emits a complete fresh packet.
REQ-038 Wrap: preload pkt_count to 16'hFFFF via 65535 packets, or use a forced value in the bench, then send one message -> pkt_count = 16'h0000.
REQ-039 Ignored input: heard_meth changed while the FSM is in PAY -> emitted payload matches the value captured at acceptance.

Source files
------------

// File: rtl/heard_serializer.sv
// heard_serializer: captures a 384-bit method/value message and streams it
// to the host link as a 13-word packet (one header word plus twelve payload
// words), counting every packet that is fully emitted.
module heard_serializer #(
    parameter logic [15:0] TAG = 16'h0001
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         heard__ENA,
    input  logic [191:0] heard_meth,
    input  logic [191:0] heard_v,
    output logic         heard__RDY,
    output logic         out__ENA,
    output logic [31:0]  out_data,
    output logic         out_last,
    input  logic         out__RDY,
    output logic [15:0]  pkt_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;

    localparam logic [3:0]  LAST_IDX   = 4'd11;
    localparam logic [15:0] PAY_WORDS  = 16'd12;

    logic [1:0]   state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [383:0] hold_q, hold_d;
    logic [15:0]  pkt_q, pkt_d;

    logic accept;
    logic xfer;

    // Handshake decodes; ready depends only on registered state so there is
    // no combinational path from either enable input back to heard__RDY.
    assign heard__RDY = (state_q == ST_IDLE);
    assign out__ENA   = (state_q == ST_HDR) || (state_q == ST_PAY);
    assign accept     = heard__ENA && heard__RDY;
    assign xfer       = out__ENA && out__RDY;
    assign pkt_count  = pkt_q;

    // Next-state logic: the holding register is written only on acceptance,
    // the word index only advances on a transfer, and the packet counter
    // bumps on the transfer of the final payload word.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        pkt_d   = pkt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    hold_d  = {heard_v, heard_meth};
                    idx_d   = 4'd0;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    idx_d   = 4'd0;
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 4'd0;
                        pkt_d   = pkt_q + 16'd1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                idx_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset wins over any
    // simultaneous acceptance or transfer, discarding an in-flight packet.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            hold_q  <= '0;
            pkt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            pkt_q   <= pkt_d;
        end
    end

    // Output word mux: header in HDR, holding-register word k in PAY (method
    // words occupy the low half, value words the high half), zero when idle.
    always_comb begin
        out_data = 32'h0;
        out_last = 1'b0;
        case (state_q)
            ST_HDR: out_data = {TAG, PAY_WORDS};
            ST_PAY: begin
                out_data = hold_q[{idx_q, 5'd0} +: 32];
                out_last = (idx_q == LAST_IDX);
            end
            default: out_data = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_heard_serializer.sv
// tb_heard_serializer: directed bench for heard_serializer covering reset,
// single packet, backpressure, back-to-back, mid-packet reset, counter wrap
// and input isolation after acceptance.
module tb_heard_serializer;

    logic         CLK = 1'b0;
    logic         RST;
    logic         heard__ENA;
    logic [191:0] heard_meth;
    logic [191:0] heard_v;
    logic         heard__RDY;
    logic         out__ENA;
    logic [31:0]  out_data;
    logic         out_last;
    logic         out__RDY;
    logic [15:0]  pkt_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] expPkt = 16'd0;

    logic [191:0] methA, vA, methB, vB;

    heard_serializer #(.TAG(16'h0001)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .heard__ENA (heard__ENA),
        .heard_meth (heard_meth),
        .heard_v    (heard_v),
        .heard__RDY (heard__RDY),
        .out__ENA   (out__ENA),
        .out_data   (out_data),
        .out_last   (out_last),
        .out__RDY   (out__RDY),
        .pkt_count  (pkt_count)
    );

    always #5 CLK = ~CLK;

    // Single comparison point: counts, asserts and reports on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic applyStimulus();
        @(posedge CLK);
        #1;
    endtask

    // Expected word i of a packet built from the given message.
    function automatic logic [31:0] expWord(input int i, input logic [191:0] m,
                                            input logic [191:0] v);
        if (i == 0)      return 32'h0001000C;
        else if (i <= 6) return m[(i-1)*32 +: 32];
        else             return v[(i-7)*32 +: 32];
    endfunction

    // Consume one packet starting from the cycle the header is presented.
    // stallMode 1 drives out__RDY as 1,0,0,1,0,0,...; a stalled word must be
    // re-presented unchanged, so comparing against the same index each cycle
    // also catches instability, drops and duplicates.
    task automatic collectPacket(input logic [191:0] m, input logic [191:0] v,
                                 input int stallMode, input int stopAfter);
        int idx = 0;
        int cyc = 0;
        logic rdy;
        while (idx < stopAfter && cyc < 200) begin
            rdy = (stallMode == 0) ? 1'b1 : ((cyc % 3) == 0);
            out__RDY = rdy;
            checkOutput($sformatf("busy_rdy[%0d]", idx), {31'd0, heard__RDY}, 32'd0);
            checkOutput($sformatf("ena[%0d]", idx), {31'd0, out__ENA}, 32'd1);
            checkOutput($sformatf("word[%0d]", idx), out_data, expWord(idx, m, v));
            checkOutput($sformatf("last[%0d]", idx), {31'd0, out_last},
                        {31'd0, (idx == 12)});
            applyStimulus();
            if (rdy) idx++;
            cyc++;
        end
        checkOutput("packet_timeout", idx, stopAfter);
        out__RDY = 1'b1;
    endtask

    // Present a message for one edge, then scramble the inputs so any late
    // sampling of heard_meth/heard_v shows up in the payload.
    task automatic sendMessage(input logic [191:0] m, input logic [191:0] v);
        heard_meth = m;
        heard_v    = v;
        heard__ENA = 1'b1;
        applyStimulus();
        heard__ENA = 1'b0;
        heard_meth = ~m;
        heard_v    = {v[95:0], v[191:96]} ^ 192'h5A5A;
        checkOutput("accept_latency", {31'd0, out__ENA}, 32'd1);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_rdy"},  {31'd0, heard__RDY}, 32'd1);
        checkOutput({tag, "_ena"},  {31'd0, out__ENA}, 32'd0);
        checkOutput({tag, "_last"}, {31'd0, out_last}, 32'd0);
        checkOutput({tag, "_data"}, out_data, 32'd0);
        checkOutput({tag, "_pkt"},  {16'd0, pkt_count}, {16'd0, expPkt});
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            methA[i*32 +: 32] = 32'(i + 1);
            vA[i*32 +: 32]    = 32'hA0 + 32'(i);
            methB[i*32 +: 32] = 32'hB000_0000 + 32'(i * 17);
            vB[i*32 +: 32]    = 32'hC0DE_0000 + 32'(i * 3);
        end

        // Reset with a simultaneous enable, which must be dropped.
        RST        = 1'b1;
        heard__ENA = 1'b1;
        heard_meth = methB;
        heard_v    = vB;
        out__RDY   = 1'b1;
        applyStimulus();
        applyStimulus();
        heard__ENA = 1'b0;
        checkIdle("reset");
        RST = 1'b0;
        applyStimulus();
        checkIdle("post_reset");

        // Single message, link always ready; inputs change after acceptance.
        $display("[TB] single message");
        sendMessage(methA, vA);
        collectPacket(methA, vA, 0, 13);
        expPkt = 16'd1;
        checkIdle("single_done");

        // Same message under backpressure.
        $display("[TB] backpressure");
        sendMessage(methA, vA);
        collectPacket(methA, vA, 1, 13);
        expPkt = 16'd2;
        checkIdle("bp_done");

        // Back-to-back: enable held high across two messages.
        $display("[TB] back-to-back");
        heard_meth = methA;
        heard_v    = vA;
        heard__ENA = 1'b1;
        applyStimulus();
        heard_meth = methB;
        heard_v    = vB;
        checkOutput("b2b_first_hdr", {31'd0, out__ENA}, 32'd1);
        collectPacket(methA, vA, 0, 13);
        expPkt = 16'd3;
        checkOutput("b2b_gap_rdy", {31'd0, heard__RDY}, 32'd1);
        checkOutput("b2b_gap_pkt", {16'd0, pkt_count}, {16'd0, expPkt});
        applyStimulus();
        heard__ENA = 1'b0;
        checkOutput("b2b_second_hdr", {31'd0, out__ENA}, 32'd1);
        collectPacket(methB, vB, 0, 13);
        expPkt = 16'd4;
        checkIdle("b2b_done");

        // Mid-packet reset after five transferred words.
        $display("[TB] mid-packet reset");
        RST = 1'b1;
        applyStimulus();
        RST = 1'b0;
        expPkt = 16'd0;
        checkIdle("pre_mid");
        sendMessage(methB, vB);
        collectPacket(methB, vB, 0, 5);
        RST = 1'b1;
        applyStimulus();
        RST = 1'b0;
        checkIdle("mid_reset");
        sendMessage(methA, vA);
        collectPacket(methA, vA, 0, 13);
        expPkt = 16'd1;
        checkIdle("mid_fresh");

        // Counter wrap from a forced 16'hFFFF.
        $display("[TB] counter wrap");
        force dut.pkt_q = 16'hFFFF;
        #1;
        release dut.pkt_q;
        applyStimulus();
        expPkt = 16'hFFFF;
        checkIdle("wrap_pre");
        sendMessage(methB, vB);
        collectPacket(methB, vB, 0, 13);
        expPkt = 16'h0000;
        checkIdle("wrap_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
